// File: rtl/gf163_mul_seq.sv
// gf163_mul_seq: sequencer for an external digit-serial GF(2^163) systolic multiplier.
//
// Latches operands a, b and the reduction polynomial g on an accepted start. It streams
// them MSB digit first to the multiplier: b leads a and g by one digit. It then collects
// the product digits from the multiplier into p.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                request an operation (sampled in IDLE only)
//   a, b, g              168-bit operands / reduction polynomial (top 5 bits zero)
//   busy                 high whenever the sequencer is not idle
//   done, err            one-cycle completion pulse; err marks an aborted operation
//   p                    product, held until the next accepted start
//   mul_a, mul_b, mul_g  registered digit streams to the multiplier
//   mul_ctr              multiplier enable
//   mul_po, mul_ctro     product digit from the multiplier and its valid flag
//
// Optional feature: define GF163_SEQ_TIMEOUT_EN to abort after TIMEOUT idle WAIT cycles.

module gf163_mul_seq #(
    parameter int unsigned DIGIT_W = 8,
    parameter int unsigned NDIG    = 21,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*NDIG-1:0]   a,
    input  logic [DIGIT_W*NDIG-1:0]   b,
    input  logic [DIGIT_W*NDIG-1:0]   g,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*NDIG-1:0]   p,
    output logic                      err,
    output logic [DIGIT_W-1:0]        mul_a,
    output logic [DIGIT_W-1:0]        mul_b,
    output logic [DIGIT_W-1:0]        mul_g,
    output logic                      mul_ctr,
    input  logic [DIGIT_W-1:0]        mul_po,
    input  logic                      mul_ctro
);

    localparam int unsigned W  = DIGIT_W * NDIG;
    localparam int unsigned KW = $clog2(NDIG + 2);
    localparam int unsigned CW = $clog2(NDIG + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

`ifdef GF163_SEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFeed, StWait, StCollect} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, g_q;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic [W-1:0]    p_d;
    logic [DIGIT_W-1:0] mul_a_d, mul_b_d, mul_g_d;
    logic            mul_ctr_d, done_d, err_d;
    logic            capture, finish, abort, timeout_hit;

    // Digit idx of x, counting from the most significant digit.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [W-1:0] x,
                                                    input int unsigned idx);
        logic [W-1:0] sh;
        sh = x >> ((NDIG - 1 - idx) * DIGIT_W);
        return sh[DIGIT_W-1:0];
    endfunction

    assign busy = (state_q != StIdle);

    // Product digits only count once feeding is over.
    assign capture     = ((state_q == StWait) || (state_q == StCollect)) && mul_ctro;
    assign finish      = capture && (cnt_q == CW'(NDIG - 1));
    // The WAIT counter always runs; the feature macro only decides whether it may abort.
    assign timeout_hit = TimeoutEn && (state_q == StWait) && !mul_ctro &&
                         (wcnt_q == TW'(TIMEOUT - 1));
    assign abort       = ((state_q == StCollect) && !mul_ctro) || timeout_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StFeed;
            StFeed:    if (k_q == KW'(NDIG + 1)) state_d = StWait;
            StWait: begin
                if (mul_ctro) begin
                    state_d = StCollect;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StCollect: if (finish || abort) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output / datapath next values. Digit outputs are registered, so each FEED cycle
    // prepares the digits belonging to feed step k+1.
    always_comb begin
        k_d       = k_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        p_d       = p;
        mul_a_d   = '0;
        mul_b_d   = '0;
        mul_g_d   = '0;
        mul_ctr_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = '0;
                    cnt_d   = '0;
                    p_d     = '0;
                    mul_b_d = digit_of(b, 0);
                end
            end
            StFeed: begin
                k_d       = k_q + 1'b1;
                wcnt_d    = '0;
                mul_ctr_d = 1'b1;
                if (k_q < KW'(NDIG - 1)) begin
                    mul_b_d = digit_of(b_q, 32'(k_q) + 32'd1);
                end
                if (k_q < KW'(NDIG)) begin
                    mul_a_d = digit_of(a_q, 32'(k_q));
                    mul_g_d = digit_of(g_q, 32'(k_q));
                end
            end
            StWait, StCollect: begin
                mul_ctr_d = 1'b1;
                if (capture) begin
                    p_d   = {p[W-DIGIT_W-1:0], mul_po};
                    cnt_d = cnt_q + 1'b1;
                end else if (state_q == StWait) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (finish) begin
                    done_d    = 1'b1;
                    mul_ctr_d = 1'b0;
                end
                if (abort) begin
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    p_d       = '0;
                    mul_ctr_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            p       <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_g   <= '0;
            mul_ctr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if ((state_q == StIdle) && start) begin
                a_q <= a;
                b_q <= b;
                g_q <= g;
            end
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            p       <= p_d;
            mul_a   <= mul_a_d;
            mul_b   <= mul_b_d;
            mul_g   <= mul_g_d;
            mul_ctr <= mul_ctr_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_gf163_mul_seq.sv
// Self-checking bench for gf163_mul_seq: a behavioural multiplier model answers the digit
// stream, and a GF(2^163) reference computes the expected product from the original operands.
module tb_gf163_mul_seq;

    localparam logic [167:0] GPOLY = 168'h1920;
    localparam logic [162:0] FLOW  = 163'h0C9;  // x^7 + x^6 + x^3 + 1

    logic         clk = 1'b0;
    logic         rst, start;
    logic [167:0] a, b, g;
    logic         busy, done, err;
    logic [167:0] p;
    logic [7:0]   mul_a, mul_b, mul_g, mul_po;
    logic         mul_ctr, mul_ctro;

    int n_cmp = 0;
    int n_mis = 0;

    // Observations of the latest operation
    logic [7:0]   obs_a [0:22];
    logic [7:0]   obs_b [0:22];
    logic [7:0]   obs_g [0:22];
    logic         obs_c [0:22];
    logic         obs_done, obs_err, obs_busy, obs_ctr, obs_done_next, obs_early;
    logic [167:0] obs_p;
    logic [23:0]  obs_dig;
    logic         obs_wait_ctr;
    logic [23:0]  obs_wait_dig;

    gf163_mul_seq #(.DIGIT_W(8), .NDIG(21), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .g        (g),
        .busy     (busy),
        .done     (done),
        .p        (p),
        .err      (err),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_g    (mul_g),
        .mul_ctr  (mul_ctr),
        .mul_po   (mul_po),
        .mul_ctro (mul_ctro)
    );

    always #5 clk = ~clk;

    // x * y * x mod (x^163 + low); the modelled array returns the product scaled by x.
    function automatic logic [167:0] gf_mulx(input logic [167:0] x, input logic [167:0] y,
                                             input logic [162:0] low);
        logic [163:0] r;
        logic [163:0] f;
        f = {1'b1, low};
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r << 1;
            if (r[163]) r = r ^ f;
            if (y[i]) r = r ^ {1'b0, x[162:0]};
        end
        r = r << 1;
        if (r[163]) r = r ^ f;
        return {5'b0, r[162:0]};
    endfunction

    function automatic logic [167:0] rnd168();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        t[191:163] = '0;
        return t[167:0];
    endfunction

    // Drives one operation from a sample point (#1 after a rising edge) and records what
    // the DUT shows. drop_after: number of product digits delivered (21 = all, 0 = stop in
    // WAIT and return). rst_k >= 0 resets at that feed step.
    task automatic run_op(input logic [167:0] ta, input logic [167:0] tbv,
                          input logic [167:0] tg, input int lat, input int drop_after,
                          input bit poke, input int rst_k, input bit junk);
        logic [167:0] ra, rb, rg, prod;
        a = ta; b = tbv; g = tg; start = 1'b1;
        obs_early = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            obs_a[k] = mul_a; obs_b[k] = mul_b; obs_g[k] = mul_g; obs_c[k] = mul_ctr;
            obs_early |= (done === 1'b1);
            start    = poke && (k == 5);
            if (start) a = rnd168();
            mul_ctro = junk ? 1'($urandom() % 2) : 1'b0;
            mul_po   = 8'($urandom());
            if (k == rst_k) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; mul_ctro = 1'b0;
                obs_done = done; obs_err = err; obs_p = p; obs_busy = busy;
                obs_ctr = mul_ctr; obs_dig = {mul_a, mul_b, mul_g};
                obs_done_next = 1'b0;
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk); #1;
                    obs_done_next |= (done !== 1'b0);
                    obs_busy |= (busy !== 1'b0);
                end
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mul_ctro = 1'b0; mul_po = '0;
        obs_wait_ctr = mul_ctr;
        obs_wait_dig = {mul_a, mul_b, mul_g};
        if (drop_after == 0) return;
        // Multiplier model: rebuild operands from the stream and answer after lat cycles.
        ra = '0; rb = '0; rg = '0;
        for (int k = 0; k < 21; k++) begin
            rb = {rb[159:0], obs_b[k]};
            ra = {ra[159:0], obs_a[k+1]};
            rg = {rg[159:0], obs_g[k+1]};
        end
        prod = gf_mulx(ra, rb, rg[167:5]);
        for (int c = 0; c < lat; c++) begin
            obs_early |= (done === 1'b1);
            @(posedge clk); #1;
        end
        for (int j = 0; j < 21; j++) begin
            if (j == drop_after) break;
            mul_po   = prod[167 - 8*j -: 8];
            mul_ctro = 1'b1;
            start    = poke && (j == 3);
            obs_early |= (done === 1'b1);
            @(posedge clk); #1;
        end
        mul_ctro = 1'b0; mul_po = '0; start = 1'b0;
        if (drop_after < 21) begin
            obs_early |= (done === 1'b1);
            @(posedge clk); #1;
        end
        obs_done = done; obs_err = err; obs_p = p; obs_busy = busy; obs_ctr = mul_ctr;
        obs_dig = {mul_a, mul_b, mul_g};
        @(posedge clk); #1;
        obs_done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = rnd168(); b = rnd168(); g = GPOLY;
        mul_ctro = 1'b0; mul_po = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({busy, done, err, mul_ctr, mul_a, mul_b, mul_g, p} !== '0) begin
                n_mis++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b err=%b ctr=%b dig=%h p=%h, want all 0",
                         c, busy, done, err, mul_ctr, {mul_a, mul_b, mul_g}, p);
            end
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || mul_ctr !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_no_feed: got busy=%b ctr=%b, want 0 0", busy, mul_ctr);
        end
    endtask

    task automatic test_digit_order();
        logic [167:0] ta, tbv, exp_p;
        logic [24:0]  exp_v;
        ta = 168'h1; tbv = 168'h2;
        run_op(ta, tbv, GPOLY, 3, 21, 1'b0, -1, 1'b1);
        for (int k = 0; k <= 22; k++) begin
            exp_v = '0;
            if (k <= 20) exp_v[15:8] = tbv[167 - 8*k -: 8];
            if (k >= 1 && k <= 21) begin
                exp_v[23:16] = ta[167 - 8*(k-1) -: 8];
                exp_v[7:0]   = GPOLY[167 - 8*(k-1) -: 8];
            end
            exp_v[24] = (k >= 1);
            n_cmp++;
            if ({obs_c[k], obs_a[k], obs_b[k], obs_g[k]} !== exp_v) begin
                n_mis++;
                $display("FAIL digit_order k=%0d: got ctr/a/b/g=%h, want %h", k,
                         {obs_c[k], obs_a[k], obs_b[k], obs_g[k]}, exp_v);
            end
        end
        exp_p = gf_mulx(ta, tbv, FLOW);
        n_cmp++;
        if (obs_p !== exp_p || obs_p !== 168'h4) begin
            n_mis++;
            $display("FAIL small_product: got p=%h, want %h (4)", obs_p, exp_p);
        end
        n_cmp++;
        if ({obs_done, obs_err, obs_busy, obs_ctr, obs_early, obs_done_next} !== 6'b100000) begin
            n_mis++;
            $display("FAIL small_done: got done/err/busy/ctr/early/next=%b, want 100000",
                     {obs_done, obs_err, obs_busy, obs_ctr, obs_early, obs_done_next});
        end
    endtask

    task automatic test_back_to_back();
        logic [167:0] ta, tbv, exp_p;
        for (int i = 0; i < 1000; i++) begin
            ta = rnd168(); tbv = rnd168();
            run_op(ta, tbv, GPOLY, int'($urandom_range(0, 4)), 21, 1'b0, -1,
                   1'($urandom() % 2));
            exp_p = gf_mulx(ta, tbv, FLOW);
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_mis++;
                $display("FAIL b2b_product[%0d]: got %h, want %h", i, obs_p, exp_p);
            end
            n_cmp++;
            if ({obs_done, obs_err, obs_early, obs_done_next} !== 4'b1000) begin
                n_mis++;
                $display("FAIL b2b_status[%0d]: got done/err/early/next=%b, want 1000", i,
                         {obs_done, obs_err, obs_early, obs_done_next});
            end
            n_cmp++;
            if ({obs_wait_ctr, obs_wait_dig} !== {1'b1, 24'h0}) begin
                n_mis++;
                $display("FAIL b2b_wait_outputs[%0d]: got ctr/dig=%h, want 1000000", i,
                         {obs_wait_ctr, obs_wait_dig});
            end
        end
    endtask

    task automatic test_abort();
        logic [167:0] ta, tbv;
        run_op(rnd168(), rnd168(), GPOLY, 2, 10, 1'b0, -1, 1'b0);
        n_cmp++;
        if ({obs_done, obs_err, obs_busy, obs_ctr, obs_early} !== 5'b11000 || obs_p !== '0) begin
            n_mis++;
            $display("FAIL abort: got done/err/busy/ctr/early=%b p=%h, want 11000 p=0",
                     {obs_done, obs_err, obs_busy, obs_ctr, obs_early}, obs_p);
        end
        ta = rnd168(); tbv = rnd168();
        run_op(ta, tbv, GPOLY, 1, 21, 1'b0, -1, 1'b0);
        n_cmp++;
        if (obs_p !== gf_mulx(ta, tbv, FLOW) || {obs_done, obs_err} !== 2'b10) begin
            n_mis++;
            $display("FAIL after_abort: got p=%h done=%b err=%b, want p=%h 1 0", obs_p,
                     obs_done, obs_err, gf_mulx(ta, tbv, FLOW));
        end
    endtask

    task automatic test_ignored_start();
        logic [167:0] ta, tbv;
        ta = rnd168(); tbv = rnd168();
        run_op(ta, tbv, GPOLY, 2, 21, 1'b1, -1, 1'b0);
        n_cmp++;
        if (obs_p !== gf_mulx(ta, tbv, FLOW) || {obs_done, obs_err, obs_early} !== 3'b100) begin
            n_mis++;
            $display("FAIL ignored_start: got p=%h done/err/early=%b, want p=%h 100", obs_p,
                     {obs_done, obs_err, obs_early}, gf_mulx(ta, tbv, FLOW));
        end
    endtask

    task automatic test_reset_mid();
        logic [167:0] ta, tbv;
        run_op(rnd168(), rnd168(), GPOLY, 2, 21, 1'b1, 10, 1'b0);
        n_cmp++;
        if ({obs_done, obs_err, obs_busy, obs_ctr, obs_done_next, obs_early} !== 6'b0 ||
            obs_dig !== '0 || obs_p !== '0) begin
            n_mis++;
            $display("FAIL reset_mid: got done/err/busy/ctr/late_done/early=%b dig=%h p=%h, want 0",
                     {obs_done, obs_err, obs_busy, obs_ctr, obs_done_next, obs_early},
                     obs_dig, obs_p);
        end
        ta = rnd168(); tbv = rnd168();
        run_op(ta, tbv, GPOLY, 0, 21, 1'b0, -1, 1'b0);
        n_cmp++;
        if (obs_p !== gf_mulx(ta, tbv, FLOW) || {obs_done, obs_err} !== 2'b10) begin
            n_mis++;
            $display("FAIL after_reset_mid: got p=%h done=%b err=%b, want p=%h 1 0", obs_p,
                     obs_done, obs_err, gf_mulx(ta, tbv, FLOW));
        end
    endtask

    task automatic test_timeout();
`ifdef GF163_SEQ_TIMEOUT_EN
        int cyc;
        run_op(rnd168(), rnd168(), GPOLY, 0, 0, 1'b0, -1, 1'b0);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
        n_cmp++;
        if (cyc != 64 || err !== 1'b1 || p !== '0) begin
            n_mis++;
            $display("FAIL timeout: got done after %0d cycles err=%b p=%h, want 64 1 0",
                     cyc, err, p);
        end
        @(posedge clk); #1;
`else
        logic stuck;
        run_op(rnd168(), rnd168(), GPOLY, 0, 0, 1'b0, -1, 1'b0);
        stuck = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            stuck &= (busy === 1'b1) && (done === 1'b0);
        end
        n_cmp++;
        if (stuck !== 1'b1) begin
            n_mis++;
            $display("FAIL wait_forever: got busy-held=%b, want 1", stuck);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL wait_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; g = '0; mul_po = '0; mul_ctro = 1'b0;
        test_reset();
        test_digit_order();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
